// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator.
// master drives sync/enable/strobes/coords; slave consumes them.
interface vga_timing_gen_if #(
  parameter int XW  = 10,
  parameter int YW  = 9,
  parameter int FCW = 16
);
  logic           o_hs;
  logic           o_vs;
  logic           o_de;
  logic           o_blanking;
  logic           o_line;
  logic           o_frame;
  logic           o_animate;
  logic [XW-1:0]  o_x;
  logic [YW-1:0]  o_y;
  logic [FCW-1:0] o_frame_cnt;

  modport master (
    output o_hs,
    output o_vs,
    output o_de,
    output o_blanking,
    output o_line,
    output o_frame,
    output o_animate,
    output o_x,
    output o_y,
    output o_frame_cnt
  );

  modport slave (
    input o_hs,
    input o_vs,
    input o_de,
    input o_blanking,
    input o_line,
    input o_frame,
    input o_animate,
    input o_x,
    input o_y,
    input o_frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing with letterbox window.
// Ports: i_clk, i_rst (async high), i_pix_stb, vga (master bundle).
module vga_timing_gen #(
  parameter int H_RES       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_RES       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int H_POL       = 0,
  parameter int V_POL       = 0,
  parameter int WIN_Y0      = 60,
  parameter int WIN_H       = 360,
  parameter int SCALE_SHIFT = 1,
  parameter int FCW         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_RES + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_RES + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int WIN_Y1  = WIN_Y0 + WIN_H;
  localparam int Y_LAST  = (WIN_H - 1) >> SCALE_SHIFT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_RES);
  localparam int YW      = $clog2(V_RES);
  localparam logic HS_ON = 1'(H_POL);
  localparam logic VS_ON = 1'(V_POL);

  if (WIN_Y1 > V_RES) begin : g_err_win
    $error("vga_timing_gen: window exceeds V_RES");
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_err_scale
    $error("vga_timing_gen: SCALE_SHIFT out of range");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_porch
    $error("vga_timing_gen: zero porch or sync width");
  end

  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic           h_last, v_last;
  int             hn, vn;
  logic           in_win;

  logic           hs_d, vs_d, de_d, bl_d;
  logic           line_d, frame_d, anim_d;
  logic [XW-1:0]  x_d;
  logic [YW-1:0]  y_d;
  logic [FCW-1:0] fcnt_d;

  logic           hs_q, vs_q, de_q, bl_q;
  logic           line_q, frame_q, anim_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic [FCW-1:0] fcnt_q;

  always_comb begin : p_next_pos
    h_last = (h_q == HW'(H_TOTAL - 1));
    v_last = (v_q == VW'(V_TOTAL - 1));
    h_d    = h_last ? '0 : h_q + HW'(1);
    v_d    = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + VW'(1);
    end
  end

  // Everything is decoded from the next position so the
  // registered outputs line up with h_q/v_q.
  always_comb begin : p_decode
    hn     = int'(h_d);
    vn     = int'(v_d);
    in_win = (vn >= WIN_Y0) && (vn < WIN_Y1);
    hs_d   = (hn >= HS_BEG && hn < HS_END) ? HS_ON : ~HS_ON;
    vs_d   = (vn >= VS_BEG && vn < VS_END) ? VS_ON : ~VS_ON;
    de_d   = (hn < H_RES) && in_win;
    bl_d   = (hn >= H_RES) || (vn >= V_RES);
    x_d    = '0;
    if (hn < H_RES) begin
      x_d = XW'(hn >> SCALE_SHIFT);
    end
    y_d = '0;
    unique case (1'b1)
      in_win:        y_d = YW'((vn - WIN_Y0) >> SCALE_SHIFT);
      (vn < WIN_Y0): y_d = '0;
      default:       y_d = YW'(Y_LAST);
    endcase
    line_d  = (hn == 0);
    frame_d = line_d && (vn == 0);
    anim_d  = (hn == H_RES) && (vn == WIN_Y1 - 1);
    fcnt_d  = fcnt_q + FCW'(frame_d);
  end

  // Reset parks on the last position so the first strobe
  // wraps into (0,0) and starts frame 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_q     <= HW'(H_TOTAL - 1);
      v_q     <= VW'(V_TOTAL - 1);
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      de_q    <= 1'b0;
      bl_q    <= 1'b1;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      anim_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fcnt_q  <= '1;
    end else if (i_pix_stb) begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      bl_q    <= bl_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      anim_q  <= anim_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fcnt_q  <= fcnt_d;
    end else begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      anim_q  <= 1'b0;
    end
  end

  assign vga.o_hs        = hs_q;
  assign vga.o_vs        = vs_q;
  assign vga.o_de        = de_q;
  assign vga.o_blanking  = bl_q;
  assign vga.o_line      = line_q;
  assign vga.o_frame     = frame_q;
  assign vga.o_animate   = anim_q;
  assign vga.o_x         = x_q;
  assign vga.o_y         = y_q;
  assign vga.o_frame_cnt = fcnt_q;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/DVI raster timing generator with letterbox window and power-of-two pixel scaling, the successor to the fixed 320x180 driver. It produces sync, data-enable, blanking and frame/line/animate strobes, plus scaled framebuffer coordinates, for any mode described by its parameters. It sits between the pixel-clock strobe generator and the framebuffer read / colour output logic. All outputs are registered.

## Interface
- H_RES, 640: active pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: horizontal sync width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_RES, 480: active lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vertical sync width, in lines
- V_BP, 33: vertical back porch, in lines
- H_POL, 0: horizontal sync active level (0 = active-low)
- V_POL, 0: vertical sync active level
- WIN_Y0, 60: first active line of the letterbox window
- WIN_H, 360: letterbox window height, in lines
- SCALE_SHIFT, 1: coordinate divide, 2^SCALE_SHIFT; legal values 0..3
- FCW, 16: frame counter width
- i_clk, in, 1: base clock
- i_rst, in, 1: reset; asynchronous, active-high
- i_pix_stb, in, 1: pixel strobe; the position advances once per i_clk edge on which this is high
- o_hs, out, 1: horizontal sync (polarity per H_POL)
- o_vs, out, 1: vertical sync (polarity per V_POL)
- o_de, out, 1: drawing pixel inside the letterbox window
- o_blanking, out, 1: outside the raw active area (h>=H_RES or v>=V_RES)
- o_line, out, 1: one-clock strobe on entering h=0 of any line
- o_frame, out, 1: one-clock strobe on entering (0,0)
- o_animate, out, 1: one-clock strobe on entering (H_RES, WIN_Y0+WIN_H-1)
- o_x, out, $clog2(H_RES): scaled x
- o_y, out, $clog2(V_RES): scaled y
- o_frame_cnt, out, FCW: frame number

## Operation
- Totals: H_TOTAL=H_RES+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL=V_RES+V_FP+V_SYNC+V_BP (525 by default).
- Position registers h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1.
  - On a strobe with h=H_TOTAL-1: h wraps to 0 and v increments.
  - On a strobe with h=H_TOTAL-1 and v=V_TOTAL-1: both wrap to 0.
- Raster order: active pixels first, then front porch, sync, back porch.
  - Sync is asserted for h in [H_RES+H_FP, H_RES+H_FP+H_SYNC).
  - Vertical sync follows the same pattern on v.
- Window: rows v in [WIN_Y0, WIN_Y0+WIN_H).
  - o_de = (h<H_RES) & v in window.
  - Active rows outside the window are letterbox bars: o_de=0 and o_blanking=0. Downstream logic drives black there.
- o_x:
  - h>>SCALE_SHIFT while h<H_RES.
  - 0 while h>=H_RES.
- o_y:
  - (v-WIN_Y0)>>SCALE_SHIFT inside the window.
  - 0 above the window.
  - (WIN_H-1)>>SCALE_SHIFT below the window, including vertical blanking.
- Frame counter: o_frame_cnt increments modulo 2^FCW on every entry to (0,0).
- Elaboration fails if WIN_Y0+WIN_H>V_RES, SCALE_SHIFT>3, or any porch/sync parameter is 0.

## Timing
- Reset (asynchronous, immediate):
  - Position is forced to (H_TOTAL-1, V_TOTAL-1).
  - o_hs=~H_POL, o_vs=~V_POL, o_de=0, o_blanking=1.
  - o_line=o_frame=o_animate=0, o_x=0, o_y=0.
  - o_frame_cnt is all-ones.
- After reset: the first i_pix_stb enters (0,0), fires o_line and o_frame, and sets o_frame_cnt=0.
- Reset asserted mid-frame behaves identically; there is no partial-frame state.
- Outputs are computed from the next position and registered on the same edge that updates h/v. They describe the current position with zero latency relative to the position registers.
- o_line, o_frame and o_animate are high for exactly one i_clk cycle, the cycle after the entering edge, even when i_pix_stb is sparse.
- With i_pix_stb held high, the generator advances every clock. With gaps, all level outputs hold their values.
- Entering (0,0) raises o_line and o_frame in the same cycle.

## Test plan
- Default parameters, i_pix_stb continuously high, run 2 frames -> 525 o_line strobes per frame; o_hs low for 96 clocks starting at h=656; o_vs low for lines 490-491; o_frame period is 420000 clocks; o_frame_cnt goes 0 then 1.
- Window/scaling: at (159,59) -> o_de=0, o_blanking=0, o_y=0. At (160,60) -> o_de=1, o_x=80, o_y=0. At (639,419) -> o_x=319, o_y=179. At (0,420) -> o_de=0, o_y=179.
- Animate: o_animate is a single pulse on entering (640,419), once per frame.
- Sparse strobe (1 in 4 clocks) -> positions and counts match the continuous run scaled by 4; strobes remain 1 clock wide.
- Reset asserted mid-line at (300,200), asynchronously between edges -> outputs take their reset values before the next edge; the first strobe after release gives o_frame=1 and o_frame_cnt=0.
- Override H_POL=1, V_POL=1, SCALE_SHIFT=0, WIN_Y0=0, WIN_H=480 -> sync pulses are active-high; o_de covers the full 640x480 area; o_x=h, o_y=v.
